branch_predictor_bht: RTL and testbench

- Parametrised successor to the fetch-stage static predictor.
- Decodes conditional-branch and JAL immediates with correct sign extension.
- Predicts conditional branches from a table of 2-bit saturating counters. MODE selects bimodal or gshare indexing.
- Sits between Fetcher and RS. It answers the Fetcher one cycle after a request and is trained by the RS on branch resolution.

---
 rtl/branch_predictor_bht.sv | 120 ++++++++++++
 tb/tb_branch_predictor_bht.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// Branch predictor with a table of 2-bit saturating counters, bimodal or gshare indexed.
// Answers a fetch request one cycle later and is trained by the RS on branch resolution.
module branch_predictor_bht #(
  parameter int unsigned INDEX_BITS = 6,
  parameter int unsigned MODE       = 0,
  parameter int unsigned HIST_BITS  = 6,
  parameter logic [1:0]  INIT_CTR   = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  Fetch_Valid,
  input  logic [31:0]           PC,
  input  logic [31:0]           Inst,
  output logic                  Predict_Valid,
  output logic [31:0]           Predict_Jump,
  output logic                  Predict_Taken,
  output logic [INDEX_BITS-1:0] Predict_Index,
  input  logic                  Train_Valid,
  input  logic [INDEX_BITS-1:0] Train_Index,
  input  logic                  Train_Taken
);

  localparam int unsigned Entries  = 1 << INDEX_BITS;
  localparam logic [6:0]  OpBranch = 7'b1100011;
  localparam logic [6:0]  OpJal    = 7'b1101111;

  logic [1:0]            ctr_q [Entries];
  logic [1:0]            ctr_d [Entries];
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;

  logic                  valid_q, valid_d;
  logic                  taken_q, taken_d;
  logic [31:0]           jump_q, jump_d;
  logic [INDEX_BITS-1:0] index_q, index_d;

  logic [6:0]            opcode;
  logic [31:0]           imm_b, imm_j, pc_plus4;
  logic [INDEX_BITS-1:0] pc_idx, hist_idx, pred_idx;
  logic [1:0]            pred_ctr;

  assign opcode   = Inst[6:0];
  assign imm_b    = {{19{Inst[31]}}, Inst[31], Inst[7], Inst[30:25], Inst[11:8], 1'b0};
  assign imm_j    = {{11{Inst[31]}}, Inst[31], Inst[19:12], Inst[20], Inst[30:21], 1'b0};
  assign pc_plus4 = PC + 32'd4;

  // PC[1:0] never contributes to the index
  assign pc_idx   = PC[INDEX_BITS+1:2];
  assign hist_idx = INDEX_BITS'(ghr_q);
  assign pred_idx = (MODE == 1) ? (pc_idx ^ hist_idx) : pc_idx;
  // Table read uses the registered state, so a same-cycle train is not seen yet
  assign pred_ctr = ctr_q[pred_idx];

  always_comb begin
    valid_d = valid_q;
    taken_d = taken_q;
    jump_d  = jump_q;
    index_d = index_q;
    if (rdy) begin
      if (Fetch_Valid) begin
        valid_d = 1'b1;
        index_d = pred_idx;
        case (opcode)
          OpBranch: begin
            taken_d = pred_ctr[1];
            jump_d  = pred_ctr[1] ? (PC + imm_b) : pc_plus4;
          end
          OpJal: begin
            taken_d = 1'b1;
            jump_d  = PC + imm_j;
          end
          default: begin
            taken_d = 1'b0;
            jump_d  = pc_plus4;
          end
        endcase
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_comb begin
    ctr_d = ctr_q;
    ghr_d = ghr_q;
    if (rdy && Train_Valid) begin
      if (Train_Taken) begin
        if (ctr_q[Train_Index] != 2'b11) ctr_d[Train_Index] = ctr_q[Train_Index] + 2'd1;
      end else begin
        if (ctr_q[Train_Index] != 2'b00) ctr_d[Train_Index] = ctr_q[Train_Index] - 2'd1;
      end
      // History is committed only on resolution, never speculatively
      if (MODE == 1) ghr_d = HIST_BITS'({ghr_q, Train_Taken});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < Entries; i++) ctr_q[i] <= INIT_CTR;
      ghr_q   <= '0;
      valid_q <= 1'b0;
      taken_q <= 1'b0;
      jump_q  <= '0;
      index_q <= '0;
    end else begin
      ctr_q   <= ctr_d;
      ghr_q   <= ghr_d;
      valid_q <= valid_d;
      taken_q <= taken_d;
      jump_q  <= jump_d;
      index_q <= index_d;
    end
  end

  assign Predict_Valid = valid_q;
  assign Predict_Taken = taken_q;
  assign Predict_Jump  = jump_q;
  assign Predict_Index = index_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Bench for branch_predictor_bht: bimodal and gshare instances share stimulus; a reference
// model feeds a scoreboard, and a vector table adds fixed expectations for the bimodal one.
module tb_branch_predictor_bht;

  logic        clk = 1'b0;
  logic        rst, rdy, fetch_valid, train_valid, train_taken;
  logic [31:0] pc, inst;
  logic [5:0]  train_index;

  logic        p0_valid, p0_taken, p1_valid, p1_taken;
  logic [31:0] p0_jump, p1_jump;
  logic [5:0]  p0_idx, p1_idx;

  always #5 clk = ~clk;

  branch_predictor_bht #(.INDEX_BITS(6), .MODE(0), .HIST_BITS(6), .INIT_CTR(2'b01)) dut0 (
    .clk(clk), .rst(rst), .rdy(rdy), .Fetch_Valid(fetch_valid), .PC(pc), .Inst(inst),
    .Predict_Valid(p0_valid), .Predict_Jump(p0_jump), .Predict_Taken(p0_taken),
    .Predict_Index(p0_idx), .Train_Valid(train_valid), .Train_Index(train_index),
    .Train_Taken(train_taken)
  );

  branch_predictor_bht #(.INDEX_BITS(6), .MODE(1), .HIST_BITS(6), .INIT_CTR(2'b01)) dut1 (
    .clk(clk), .rst(rst), .rdy(rdy), .Fetch_Valid(fetch_valid), .PC(pc), .Inst(inst),
    .Predict_Valid(p1_valid), .Predict_Jump(p1_jump), .Predict_Taken(p1_taken),
    .Predict_Index(p1_idx), .Train_Valid(train_valid), .Train_Index(train_index),
    .Train_Taken(train_taken)
  );

  typedef struct {
    logic        valid;
    logic        taken;
    logic [31:0] jump;
    logic [5:0]  idx;
  } exp_t;

  typedef struct {
    logic        r, fv;
    logic [31:0] p, i;
    logic        tv;
    logic [5:0]  ti;
    logic        tt;
    logic        ev, et;
    logic [31:0] ej;
    logic [5:0]  ei;
  } vec_t;

  localparam logic [31:0] InstBeqP8  = 32'h0000_0463;
  localparam logic [31:0] InstBeqM8  = 32'hFE00_0CE3;
  localparam logic [31:0] InstJalM4  = 32'hFFDF_F06F;
  localparam logic [31:0] InstNop    = 32'h0000_0013;

  exp_t        sb_q[$];
  exp_t        m_out[2];
  logic [1:0]  m_ctr[2][64];
  logic [5:0]  m_ghr[2];
  vec_t        vecs[$];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 64; k++) m_ctr[d][k] = 2'b01;
      m_ghr[d] = '0;
      m_out[d].valid = 1'b0;
      m_out[d].taken = 1'b0;
      m_out[d].jump  = '0;
      m_out[d].idx   = '0;
    end
    sb_q.delete();
  endtask

  // Advances the model across one clock edge and queues the expected outputs
  task automatic model_cycle();
    logic [5:0]  idx;
    logic [31:0] ib, ij;
    ib = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    ij = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    for (int d = 0; d < 2; d++) begin
      if (rdy) begin
        idx = (d == 1) ? (pc[7:2] ^ m_ghr[d]) : pc[7:2];
        if (fetch_valid) begin
          m_out[d].valid = 1'b1;
          m_out[d].idx   = idx;
          if (inst[6:0] == 7'b1100011) begin
            m_out[d].taken = m_ctr[d][idx][1];
            m_out[d].jump  = m_ctr[d][idx][1] ? pc + ib : pc + 32'd4;
          end else if (inst[6:0] == 7'b1101111) begin
            m_out[d].taken = 1'b1;
            m_out[d].jump  = pc + ij;
          end else begin
            m_out[d].taken = 1'b0;
            m_out[d].jump  = pc + 32'd4;
          end
        end else begin
          m_out[d].valid = 1'b0;
        end
        if (train_valid) begin
          if (train_taken && m_ctr[d][train_index] != 2'b11)
            m_ctr[d][train_index] = m_ctr[d][train_index] + 2'd1;
          else if (!train_taken && m_ctr[d][train_index] != 2'b00)
            m_ctr[d][train_index] = m_ctr[d][train_index] - 2'd1;
          if (d == 1) m_ghr[d] = {m_ghr[d][4:0], train_taken};
        end
      end
      sb_q.push_back(m_out[d]);
    end
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL %s: scoreboard empty for dut%0d", tag, d);
      end else begin
        e = sb_q.pop_front();
        check($sformatf("%s dut%0d valid", tag, d), d ? p1_valid : p0_valid, e.valid);
        check($sformatf("%s dut%0d taken", tag, d), d ? p1_taken : p0_taken, e.taken);
        check($sformatf("%s dut%0d jump", tag, d), d ? p1_jump : p0_jump, e.jump);
        check($sformatf("%s dut%0d index", tag, d), d ? p1_idx : p0_idx, e.idx);
      end
    end
  endtask

  // Called just after a falling edge; returns just after the next falling edge
  task automatic step(input logic r, input logic fv, input logic [31:0] p, input logic [31:0] i,
                      input logic tv, input logic [5:0] ti, input logic tt, input string tag);
    rdy = r; fetch_valid = fv; pc = p; inst = i;
    train_valid = tv; train_index = ti; train_taken = tt;
    model_cycle();
    @(posedge clk);
    @(negedge clk);
    compare_outputs(tag);
  endtask

  task automatic check_zero(input string tag);
    check({tag, " dut0 valid"}, p0_valid, 1'b0);
    check({tag, " dut0 taken"}, p0_taken, 1'b0);
    check({tag, " dut0 jump"}, p0_jump, 32'h0);
    check({tag, " dut0 index"}, p0_idx, 6'd0);
    check({tag, " dut1 valid"}, p1_valid, 1'b0);
    check({tag, " dut1 taken"}, p1_taken, 1'b0);
    check({tag, " dut1 jump"}, p1_jump, 32'h0);
    check({tag, " dut1 index"}, p1_idx, 6'd0);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b0;
    #1;
    check_zero(tag);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic vec_t mk(input logic r, input logic fv, input logic [31:0] p,
                              input logic [31:0] i, input logic tv, input logic [5:0] ti,
                              input logic tt, input logic ev, input logic et,
                              input logic [31:0] ej, input logic [5:0] ei);
    vec_t v;
    v.r = r; v.fv = fv; v.p = p; v.i = i; v.tv = tv; v.ti = ti; v.tt = tt;
    v.ev = ev; v.et = et; v.ej = ej; v.ei = ei;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b0; fetch_valid = 1'b0; train_valid = 1'b0;
    train_taken = 1'b0; train_index = '0; pc = '0; inst = '0;

    // Expected values for the bimodal instance, one row per cycle
    vecs.push_back(mk(1, 1, 32'h100, InstBeqP8, 0, 0, 0, 1, 0, 32'h104, 0));
    vecs.push_back(mk(1, 0, 32'h0, 32'h0, 1, 0, 1, 0, 0, 32'h104, 0));
    vecs.push_back(mk(1, 1, 32'h100, InstBeqP8, 0, 0, 0, 1, 1, 32'h108, 0));
    for (int k = 0; k < 3; k++) vecs.push_back(mk(1, 0, 32'h0, 32'h0, 1, 0, 1, 0, 1, 32'h108, 0));
    vecs.push_back(mk(1, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1, 32'h108, 0));
    vecs.push_back(mk(1, 1, 32'h100, InstBeqP8, 0, 0, 0, 1, 1, 32'h108, 0));
    vecs.push_back(mk(1, 0, 32'h0, 32'h0, 1, 0, 0, 0, 1, 32'h108, 0));
    vecs.push_back(mk(1, 1, 32'h100, InstBeqP8, 0, 0, 0, 1, 0, 32'h104, 0));
    for (int k = 0; k < 2; k++) vecs.push_back(mk(1, 0, 32'h0, 32'h0, 1, 0, 1, 0, 0, 32'h104, 0));
    vecs.push_back(mk(1, 1, 32'h200, InstBeqM8, 0, 0, 0, 1, 1, 32'h1F8, 0));
    vecs.push_back(mk(1, 1, 32'h40, InstJalM4, 0, 0, 0, 1, 1, 32'h3C, 16));
    vecs.push_back(mk(1, 1, 32'hFFFF_FFFC, InstNop, 0, 0, 0, 1, 0, 32'h0, 63));
    for (int k = 0; k < 3; k++)
      vecs.push_back(mk(0, 1, 32'h100, InstBeqP8, 1, 63, 1, 1, 0, 32'h0, 63));
    vecs.push_back(mk(1, 1, 32'hFFFF_FFFC, InstBeqP8, 0, 0, 0, 1, 0, 32'h0, 63));
    for (int k = 0; k < 2; k++) vecs.push_back(mk(1, 0, 32'h0, 32'h0, 1, 0, 0, 0, 0, 32'h0, 63));
    vecs.push_back(mk(1, 1, 32'h100, InstBeqP8, 1, 0, 1, 1, 0, 32'h104, 0));
    vecs.push_back(mk(1, 1, 32'h100, InstBeqP8, 0, 0, 0, 1, 1, 32'h108, 0));

    #1 rst = 1'b0;
    @(negedge clk);
    do_reset("reset");

    for (int n = 0; n < vecs.size(); n++) begin
      step(vecs[n].r, vecs[n].fv, vecs[n].p, vecs[n].i, vecs[n].tv, vecs[n].ti, vecs[n].tt,
           $sformatf("vec%0d", n));
      check($sformatf("vec%0d valid", n), p0_valid, vecs[n].ev);
      check($sformatf("vec%0d taken", n), p0_taken, vecs[n].et);
      check($sformatf("vec%0d jump", n), p0_jump, vecs[n].ej);
      check($sformatf("vec%0d index", n), p0_idx, vecs[n].ei);
    end

    // gshare history T,T,N gives GHR=6, so PC 0x100 lands on index 6
    do_reset("gshare reset");
    step(1, 0, 32'h0, 32'h0, 1, 5, 1, "ghr t1");
    step(1, 0, 32'h0, 32'h0, 1, 5, 1, "ghr t2");
    step(1, 0, 32'h0, 32'h0, 1, 5, 0, "ghr n3");
    step(1, 1, 32'h100, InstBeqP8, 0, 0, 0, "gshare req");
    check("gshare index", p1_idx, 6'd6);
    check("gshare taken", p1_taken, 1'b0);
    check("gshare jump", p1_jump, 32'h104);

    // Mid-cycle asynchronous reset with a request in flight
    rdy = 1'b1; fetch_valid = 1'b1; pc = 32'h40; inst = InstJalM4;
    train_valid = 1'b1; train_index = 6'd1; train_taken = 1'b1;
    #2 rst = 1'b0;
    #1 check_zero("async reset");
    model_reset();
    @(posedge clk);
    #1 check_zero("reset held over edge");
    @(negedge clk);
    rst = 1'b1;
    step(1, 1, 32'h100, InstBeqP8, 0, 0, 0, "post reset req");
    check("post reset gshare index", p1_idx, 6'd0);
    check("post reset gshare valid", p1_valid, 1'b1);
    check("post reset gshare jump", p1_jump, 32'h104);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
